// File: rtl/sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sclk_gen                                                         |
// | Brief   : Programmable CPOL/CPHA serial clock generator with edge, sample, |
// |           shift and word-boundary strobes. Optional inter-word gap is      |
// |           enabled by defining SCLK_GEN_GAP_EN.                             |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sclk_gen #(
    parameter int DIV_W    = 8,
    parameter int MAX_BITS = 8,
    parameter int BITS_W   = $clog2(MAX_BITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    input  logic [BITS_W-1:0] nbits,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              cont,
`ifdef SCLK_GEN_GAP_EN
    input  logic [DIV_W-1:0]  gap,
`endif
    output logic              sclk,
    output logic              lead_edge,
    output logic              trail_edge,
    output logic              sample,
    output logic              shift,
    output logic              word_start,
    output logic              word_end,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [BITS_W-1:0] c_max_nbits = BITS_W'(MAX_BITS);
    localparam logic [BITS_W:0]   c_one_e     = (BITS_W+1)'(1);
    localparam logic [DIV_W-1:0]  c_one_d     = DIV_W'(1);

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_hc, w_hc_nxt;
    logic [BITS_W:0]   r_ec, w_ec_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [BITS_W-1:0] r_nbits, w_nbits_nxt;
    logic              r_cpol, w_cpol_nxt;
    logic              r_cpha, w_cpha_nxt;
    logic              r_cont, w_cont_nxt;
    logic              r_stop_pend, w_stop_pend_nxt;
`ifdef SCLK_GEN_GAP_EN
    logic [DIV_W-1:0]  r_gap, w_gap_nxt;
    logic [DIV_W-1:0]  r_gc, w_gc_nxt;
`endif

    logic r_sclk, w_sclk_nxt;
    logic r_lead, w_lead_nxt;
    logic r_trail, w_trail_nxt;
    logic r_sample, w_sample_nxt;
    logic r_shift, w_shift_nxt;
    logic r_ws, w_ws_nxt;
    logic r_we, w_we_nxt;
    logic r_busy, w_busy_nxt;
    logic r_done, w_done_nxt;

    logic [BITS_W-1:0] w_nbits_clamp;
    logic [BITS_W:0]   w_edge_cnt;
    logic              w_last_edge;
    logic              w_word_over;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hc        <= '0;
            r_ec        <= '0;
            r_div       <= '0;
            r_nbits     <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
`ifdef SCLK_GEN_GAP_EN
            r_gap       <= '0;
            r_gc        <= '0;
`endif
            r_sclk      <= 1'b0;
            r_lead      <= 1'b0;
            r_trail     <= 1'b0;
            r_sample    <= 1'b0;
            r_shift     <= 1'b0;
            r_ws        <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hc        <= w_hc_nxt;
            r_ec        <= w_ec_nxt;
            r_div       <= w_div_nxt;
            r_nbits     <= w_nbits_nxt;
            r_cpol      <= w_cpol_nxt;
            r_cpha      <= w_cpha_nxt;
            r_cont      <= w_cont_nxt;
            r_stop_pend <= w_stop_pend_nxt;
`ifdef SCLK_GEN_GAP_EN
            r_gap       <= w_gap_nxt;
            r_gc        <= w_gc_nxt;
`endif
            r_sclk      <= w_sclk_nxt;
            r_lead      <= w_lead_nxt;
            r_trail     <= w_trail_nxt;
            r_sample    <= w_sample_nxt;
            r_shift     <= w_shift_nxt;
            r_ws        <= w_ws_nxt;
            r_we        <= w_we_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign w_nbits_clamp = (nbits == '0 || nbits > c_max_nbits) ? c_max_nbits : nbits;
    assign w_edge_cnt    = r_ec + c_one_e;
    assign w_last_edge   = (w_edge_cnt == {r_nbits, 1'b0});
    // The stop decision is taken in the cycle word_end is visible, so a stop
    // arriving with the final edge still ends the transfer after this word.
    assign w_word_over   = r_we && (!r_cont || stop || r_stop_pend);

    always_comb begin
        w_state_nxt     = r_state;
        w_hc_nxt        = r_hc;
        w_ec_nxt        = r_ec;
        w_div_nxt       = r_div;
        w_nbits_nxt     = r_nbits;
        w_cpol_nxt      = r_cpol;
        w_cpha_nxt      = r_cpha;
        w_cont_nxt      = r_cont;
        w_stop_pend_nxt = r_stop_pend;
`ifdef SCLK_GEN_GAP_EN
        w_gap_nxt       = r_gap;
        w_gc_nxt        = r_gc;
`endif
        w_sclk_nxt      = r_sclk;
        w_lead_nxt      = 1'b0;
        w_trail_nxt     = 1'b0;
        w_ws_nxt        = 1'b0;
        w_we_nxt        = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sclk_nxt      = cpol;
                w_stop_pend_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                if (start) begin
                    w_div_nxt   = div;
                    w_nbits_nxt = w_nbits_clamp;
                    w_cpol_nxt  = cpol;
                    w_cpha_nxt  = cpha;
                    w_cont_nxt  = cont;
`ifdef SCLK_GEN_GAP_EN
                    w_gap_nxt   = gap;
`endif
                    w_hc_nxt    = '0;
                    w_ec_nxt    = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) w_stop_pend_nxt = 1'b1;
                if (w_word_over) begin
                    w_sclk_nxt  = r_cpol;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_hc == r_div) begin
                    w_hc_nxt    = '0;
                    w_sclk_nxt  = ~r_sclk;
                    w_lead_nxt  = w_edge_cnt[0];
                    w_trail_nxt = ~w_edge_cnt[0];
                    w_ws_nxt    = (w_edge_cnt == c_one_e);
                    w_we_nxt    = w_last_edge;
                    w_ec_nxt    = w_last_edge ? '0 : w_edge_cnt;
`ifdef SCLK_GEN_GAP_EN
                    if (w_last_edge && r_cont) begin
                        w_gc_nxt    = '0;
                        w_state_nxt = S_GAP;
                    end
`endif
                end else begin
                    w_hc_nxt = r_hc + c_one_d;
                end
            end
`ifdef SCLK_GEN_GAP_EN
            S_GAP: begin
                w_sclk_nxt = r_cpol;
                if (stop) w_stop_pend_nxt = 1'b1;
                if (w_word_over) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_gc == r_gap) begin
                    w_hc_nxt    = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_gc_nxt = r_gc + c_one_d;
                end
            end
`endif
            S_DONE: begin
                w_sclk_nxt      = r_cpol;
                w_stop_pend_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_sample_nxt = r_cpha ? w_trail_nxt : w_lead_nxt;
        w_shift_nxt  = r_cpha ? w_lead_nxt  : w_trail_nxt;
    end

    assign sclk       = r_sclk;
    assign lead_edge  = r_lead;
    assign trail_edge = r_trail;
    assign sample     = r_sample;
    assign shift      = r_shift;
    assign word_start = r_ws;
    assign word_end   = r_we;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sclk_gen                                                      |
// | Brief   : Directed self-checking bench for sclk_gen.                       |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sclk_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div = '0;
    logic [3:0] nbits = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       cont = 1'b0;
`ifdef SCLK_GEN_GAP_EN
    logic [7:0] gap = '0;
`endif
    logic sclk, lead_edge, trail_edge, sample, shift;
    logic word_start, word_end, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    int cap_busy0, cap_sclk0, n_lead, n_trail, n_samp, n_samp_hi, n_shift;
    int n_ws, n_we, n_done, first_edge, first_ws, last_we, t_done;
    int done_sclk, done_busy, bad_int, we_to_lead;

    sclk_gen #(.DIV_W(8), .MAX_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .div(div),
        .nbits(nbits), .cpol(cpol), .cpha(cpha), .cont(cont),
`ifdef SCLK_GEN_GAP_EN
        .gap(gap),
`endif
        .sclk(sclk), .lead_edge(lead_edge), .trail_edge(trail_edge),
        .sample(sample), .shift(shift), .word_start(word_start),
        .word_end(word_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the first RUN cycle (t = 0).
    task automatic do_start(input logic p, input logic h, input int d, input int nb, input logic c);
        @(negedge clk);
        cpol = p; cpha = h; div = 8'(d); nbits = 4'(nb); cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_xfer(input int budget, input int ival, input int stop_at, input int start_at);
        int t;
        int last_edge;
        t = 0; last_edge = -1;
        n_lead = 0; n_trail = 0; n_samp = 0; n_samp_hi = 0; n_shift = 0;
        n_ws = 0; n_we = 0; n_done = 0; first_edge = -1; first_ws = -1;
        last_we = -1; t_done = -1; bad_int = 0; we_to_lead = -1;
        cap_busy0 = busy; cap_sclk0 = sclk;
        while (t <= budget && n_done == 0) begin
            if (lead_edge) n_lead++;
            if (trail_edge) n_trail++;
            if (lead_edge || trail_edge) begin
                if (first_edge < 0) first_edge = t;
                if (last_edge >= 0 && (t - last_edge) != ival) bad_int++;
                last_edge = t;
            end
            if (lead_edge && last_we >= 0 && we_to_lead < 0) we_to_lead = t - last_we;
            if (sample) n_samp++;
            if (sample && sclk) n_samp_hi++;
            if (shift) n_shift++;
            if (word_start) begin
                n_ws++;
                if (first_ws < 0) first_ws = t;
            end
            if (word_end) begin
                n_we++;
                last_we = t;
            end
            if (done) begin
                n_done++; t_done = t; done_sclk = sclk; done_busy = busy;
            end
            stop  = (t == stop_at);
            start = (t == start_at);
            if (n_done == 0) begin
                @(negedge clk);
                t++;
            end
        end
        stop = 1'b0; start = 1'b0;
        if (n_done == 0) check("xfer_timeout", t, -1);
    endtask

    initial begin
        int cnt;
        // Reset: outputs at reset values even with cpol=1 at the input.
        cpol = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {lead_edge, trail_edge, sample, shift, word_start, word_end}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol1", sclk, 1);
        cpol = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol0", sclk, 0);

        // Mode 0, div=0, 8 bits, single word.
        do_start(1'b0, 1'b0, 0, 8, 1'b0);
        run_xfer(60, 1, -1, -1);
        check("m0_busy0", cap_busy0, 1);
        check("m0_sclk0", cap_sclk0, 0);
        check("m0_first_edge", first_edge, 1);
        check("m0_lead", n_lead, 8);
        check("m0_trail", n_trail, 8);
        check("m0_samp_rise", n_samp_hi, 8);
        check("m0_samp", n_samp, 8);
        check("m0_shift", n_shift, 8);
        check("m0_ws", n_ws * 100 + first_ws, 101);
        check("m0_we", n_we * 100 + last_we, 116);
        check("m0_interval", bad_int, 0);
        check("m0_done_t", t_done, 17);
        check("m0_done_state", done_sclk * 10 + done_busy, 0);

        // Mode 3, div=3, 4 bits.
        cpol = 1'b1;
        repeat (3) @(negedge clk);
        check("m3_idle_sclk", sclk, 1);
        do_start(1'b1, 1'b1, 3, 4, 1'b0);
        run_xfer(100, 4, -1, -1);
        check("m3_sclk0", cap_sclk0, 1);
        check("m3_first_edge", first_edge, 4);
        check("m3_interval", bad_int, 0);
        check("m3_samp", n_samp, 4);
        check("m3_samp_rise", n_samp_hi, 4);
        check("m3_edges", n_lead + n_trail, 8);
        check("m3_done_t", t_done, 33);
        check("m3_done_sclk", done_sclk, 1);

        // Continuous, nbits=2, div=1, stop inside word 3.
        do_start(1'b0, 1'b0, 1, 2, 1'b1);
        run_xfer(100, 2, 20, -1);
        check("cont_ws", n_ws, 3);
        check("cont_we", n_we, 3);
        check("cont_interval", bad_int, 0);
        check("cont_we_to_lead", we_to_lead, 2);
        check("cont_last_we", last_we, 24);
        check("cont_done_t", t_done, 25);
        check("cont_done_n", n_done, 1);

        // Continuous, stop coincident with the final edge of word 2.
        do_start(1'b0, 1'b0, 0, 1, 1'b1);
        run_xfer(40, 1, 4, -1);
        check("stopx_ws", n_ws, 2);
        check("stopx_done_t", t_done, 5);

        // nbits=0 clamps to 8; mid-run start ignored.
        do_start(1'b0, 1'b0, 0, 0, 1'b0);
        run_xfer(60, 1, -1, 5);
        check("clamp_edges", n_lead + n_trail, 16);
        check("clamp_ws", n_ws, 1);
        check("clamp_done_t", t_done, 17);
        // start on the done cycle is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_ign1", busy, 0);
        @(negedge clk);
        check("done_start_ign2", busy, 0);

        // Reset at edge 5 of a div=2 transfer.
        do_start(1'b0, 1'b0, 2, 4, 1'b0);
        repeat (15) @(negedge clk);
        check("rstx_edge5", {lead_edge, sclk}, 3);
        reset = 1'b1;
        @(negedge clk);
        check("rstx_sclk", sclk, 0);
        check("rstx_busy", busy, 0);
        check("rstx_done", done, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rstx_no_done", cnt, 0);
        do_start(1'b0, 1'b0, 0, 1, 1'b0);
        run_xfer(20, 1, -1, -1);
        check("rstx_after_edges", n_lead + n_trail, 2);
        check("rstx_after_done_t", t_done, 3);

`ifdef SCLK_GEN_GAP_EN
        // Gap of 3: word_end at t=2, next lead at t=7.
        gap = 8'd3;
        do_start(1'b0, 1'b0, 0, 1, 1'b1);
        run_xfer(60, 1, 7, -1);
        check("gap_span", we_to_lead, 5);
        check("gap_ws", n_ws, 2);
        check("gap_done_t", t_done, 9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
